// File: rtl/sub_32bit.sv
// 32-bit registered subtractor: Ra - Rb - cin through a two-level carry-lookahead
// adder on the inverted subtrahend, with difference and borrow-out registered.
module sub_32bit (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] Ra,
    input  logic [31:0] Rb,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    logic [31:0] b_inv;
    logic [31:0] g;
    logic [31:0] p;
    logic [31:0] c;
    logic [31:0] diff;
    logic [7:0]  grp_g;
    logic [7:0]  grp_p;
    logic [8:0]  grp_c;

    assign b_inv = ~Rb;
    assign g     = Ra & b_inv;
    assign p     = Ra ^ b_inv;

    // Each 4-bit slice reports group generate/propagate and expands its own carries
    // from the slice carry-in supplied by the second-level unit.
    for (genvar s = 0; s < 8; s++) begin : g_slice
        localparam int B = 4 * s;

        assign grp_g[s] = g[B+3]
                        | (p[B+3] & g[B+2])
                        | (p[B+3] & p[B+2] & g[B+1])
                        | (p[B+3] & p[B+2] & p[B+1] & g[B]);
        assign grp_p[s] = p[B+3] & p[B+2] & p[B+1] & p[B];

        assign c[B]   = grp_c[s];
        assign c[B+1] = g[B] | (p[B] & grp_c[s]);
        assign c[B+2] = g[B+1]
                      | (p[B+1] & g[B])
                      | (p[B+1] & p[B] & grp_c[s]);
        assign c[B+3] = g[B+2]
                      | (p[B+2] & g[B+1])
                      | (p[B+2] & p[B+1] & g[B])
                      | (p[B+2] & p[B+1] & p[B] & grp_c[s]);
    end

    // Second-level lookahead: every slice carry is a flat sum of products of the
    // group terms, so no carry ripples from slice to slice.
    always_comb begin
        logic carry0;
        logic prod;
        grp_c  = '0;
        carry0 = ~cin;
        prod   = 1'b0;
        grp_c[0] = carry0;
        for (int j = 1; j <= 8; j++) begin
            prod = carry0;
            for (int k = 0; k < j; k++) begin
                prod = prod & grp_p[k];
            end
            grp_c[j] = prod;
            for (int k = 0; k < j; k++) begin
                prod = grp_g[k];
                for (int m = k + 1; m < j; m++) begin
                    prod = prod & grp_p[m];
                end
                grp_c[j] = grp_c[j] | prod;
            end
        end
    end

    assign diff = p ^ c;

    // A missing carry out of bit 31 means the subtraction borrowed.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sum  <= 32'h0000_0000;
            cout <= 1'b0;
        end else begin
            sum  <= diff;
            cout <= ~grp_c[8];
        end
    end

endmodule

// File: tb/tb_sub_32bit.sv
// Scoreboard bench for sub_32bit: stimulus pushes expected results into a queue and
// a monitor compares them one edge later against the registered outputs.
module tb_sub_32bit;

    typedef struct {
        logic [31:0] exp_sum;
        logic        exp_cout;
        int          id;
    } expect_t;

    logic        clk;
    logic        clr;
    logic [31:0] Ra;
    logic [31:0] Rb;
    logic        cin;
    logic [31:0] sum;
    logic        cout;

    expect_t exp_q[$];
    int      errors;
    int      checks;
    int      op_id;

    sub_32bit dut (
        .clk  (clk),
        .clr  (clr),
        .Ra   (Ra),
        .Rb   (Rb),
        .cin  (cin),
        .sum  (sum),
        .cout (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain 33-bit unsigned subtraction; bit 32 is the borrow.
    function automatic logic [32:0] refSub(input logic [31:0] a, input logic [31:0] b,
                                           input logic c);
        logic [32:0] d;
        d = {1'b0, a} - {1'b0, b} - {32'd0, c};
        return d;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] exp_sum,
                               input logic exp_cout);
        checks++;
        if (sum !== exp_sum || cout !== exp_cout) begin
            errors++;
            $display("[TB] FAIL %s: got sum=%h cout=%b, expected sum=%h cout=%b",
                     name, sum, cout, exp_sum, exp_cout);
        end
    endtask

    task automatic pushExpected(input logic [31:0] a, input logic [31:0] b, input logic c);
        expect_t e;
        logic [32:0] d;
        d          = refSub(a, b, c);
        e.exp_sum  = d[31:0];
        e.exp_cout = d[32];
        e.id       = op_id;
        op_id++;
        exp_q.push_back(e);
    endtask

    // Drive one operation on the falling edge; the next rising edge captures it.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic c);
        @(negedge clk);
        Ra  = a;
        Rb  = b;
        cin = c;
        pushExpected(a, b, c);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            expect_t e;
            e = exp_q.pop_front();
            checkOutput($sformatf("op%0d", e.id), e.exp_sum, e.exp_cout);
        end
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic        c;
        int          wait_cycles;

        errors = 0;
        checks = 0;
        op_id  = 0;
        clr    = 1'b1;
        Ra     = 32'd0;
        Rb     = 32'd0;
        cin    = 1'b0;
        #2;
        checkOutput("reset_initial", 32'h0, 1'b0);
        @(negedge clk);
        clr = 1'b0;

        applyStimulus(32'd5, 32'd3, 1'b0);
        @(posedge clk);
        #3;
        clr = 1'b1;
        #1;
        checkOutput("reset_async", 32'h0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("reset_hold_edge1", 32'h0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("reset_hold_edge2", 32'h0, 1'b0);

        // Live inputs set while held in reset; release lands between edges.
        @(negedge clk);
        Ra  = 32'h0000_0009;
        Rb  = 32'h0000_0001;
        cin = 1'b0;
        #2;
        clr = 1'b0;
        pushExpected(Ra, Rb, cin);

        applyStimulus(32'hFFFF_FFFF, 32'h0000_00FF, 1'b1);
        applyStimulus(32'h0000_0000, 32'h0000_0001, 1'b0);
        applyStimulus(32'h0000_0000, 32'h0000_0000, 1'b1);
        applyStimulus(32'h8000_0000, 32'h0000_0001, 1'b0);
        applyStimulus(32'h0001_0000, 32'h0000_0001, 1'b0);
        applyStimulus(32'h1234_5678, 32'h0000_0000, 1'b0);
        applyStimulus(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
        applyStimulus(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
        applyStimulus(32'hCAFE_F00D, 32'hFFFF_FFFF, 1'b1);
        applyStimulus(32'h0000_0000, 32'hFFFF_FFFF, 1'b1);

        for (int i = 0; i < 200; i++) begin
            a = $urandom;
            b = $urandom;
            c = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: b = a;
                1: b = 32'h0;
                2: b = 32'hFFFF_FFFF;
                3: b = a + 32'($urandom_range(0, 2)) - 32'd1;
                default: ;
            endcase
            applyStimulus(a, b, c);
        end

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending results, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
